mem_ctrl: RTL

- Responder side of the core's memory request interfaces; owns the single byte-wide RAM/IO port.
- Serves three requesters:
  - instruction fetch: 4-byte reads.
  - LSB loads: 1/2/4-byte reads with sign or zero extension.
  - committed stores from the ROB: 1/2/4-byte writes.
- Serialises each request into byte beats. Returns a one-cycle completion pulse with data (loads/fetch) or a finish pulse (stores).

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_byte_assemble.sv | 21 ++
 rtl/mem_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Op codes, FSM state encoding and access-width helper shared by the
// memory controller and its byte assembler.
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } state_e;

    function automatic logic [2:0] op_bytes(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_bytes = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_bytes = 3'd2;
            default:              op_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_assemble.sv
// Builds the 32-bit load/fetch result from the collected bytes, applying
// sign or zero extension according to the load op.
module mem_byte_assemble
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] bytes_i,
    input  logic [5:0]  op_i,
    output logic [31:0] val_o
);

    always_comb begin
        case (op_i)
            OP_LB:   val_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
            OP_LH:   val_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
            OP_LBU:  val_o = {24'd0, bytes_i[7:0]};
            OP_LHU:  val_o = {16'd0, bytes_i[15:0]};
            default: val_o = bytes_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial responder for fetch, load and committed-store requests on the
// single 8-bit RAM/IO port.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_HI = 2'b11,
    parameter int         LD_Q  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        load_store_sgn,
    input  logic [5:0]  load_store_op,
    input  logic [31:0] load_store_addr,
    output logic        mem_valid,
    output logic [31:0] mem_res,
    input  logic        st_commit,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        finish_store,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic [1:0]  dbg_state
);

    state_e            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [5:0]        op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic              st_pend_q, st_pend_d;
    logic [5:0]        st_op_q, st_op_d;
    logic [31:0]       st_addr_q, st_addr_d;
    logic [31:0]       st_data_q, st_data_d;
    logic [LD_Q-1:0]   ld_pend_q, ld_pend_d;
    logic [5:0]        ld_op_q, ld_op_d;
    logic [31:0]       ld_addr_q, ld_addr_d;

    logic [2:0]        n;
    logic [31:0]       beat_addr;
    logic              throttle;
    logic [31:0]       asm_val;

    mem_byte_assemble u_asm (
        .bytes_i (buf_q),
        .op_i    (op_q),
        .val_o   (asm_val)
    );

    // Valid/ready: requests are captured into latches (store, load) or sampled
    // as a level (fetch); completions are single-cycle pulses gated by rdy.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        st_pend_d    = st_pend_q;
        st_op_d      = st_op_q;
        st_addr_d    = st_addr_q;
        st_data_d    = st_data_q;
        ld_pend_d    = ld_pend_q;
        ld_op_d      = ld_op_q;
        ld_addr_d    = ld_addr_q;
        mem_a        = '0;
        mem_dout     = '0;
        mem_wr       = 1'b0;
        if_valid     = 1'b0;
        mem_valid    = 1'b0;
        finish_store = 1'b0;
        throttle     = 1'b0;
        n            = op_bytes(op_q);
        beat_addr    = addr_q + {29'd0, k_q};

        case (state_q)
            S_IDLE: begin
                if (rdy) begin
                    k_d = 3'd0;
                    if (st_pend_q) begin
                        state_d   = S_STORE;
                        op_d      = st_op_q;
                        addr_d    = st_addr_q;
                        wdata_d   = st_data_q;
                        st_pend_d = 1'b0;
                    end else if (ld_pend_q[0] && !rollback) begin
                        state_d   = S_LOAD;
                        op_d      = ld_op_q;
                        addr_d    = ld_addr_q;
                        buf_d     = '0;
                        ld_pend_d = '0;
                    end else if (if_req && !rollback) begin
                        state_d = S_FETCH;
                        op_d    = OP_LW;
                        addr_d  = if_addr;
                        buf_d   = '0;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                // While frozen, keep presenting the previous byte address so
                // mem_din still carries the byte due on the resume cycle.
                if (!rdy && k_q != 3'd0 && k_q <= n) begin
                    mem_a = beat_addr - 32'd1;
                end else if (k_q < n) begin
                    mem_a = beat_addr;
                end
                if (rdy) begin
                    if (rollback) begin
                        state_d = S_IDLE;
                    end else if (k_q == n + 3'd1) begin
                        if_valid  = (state_q == S_FETCH);
                        mem_valid = (state_q == S_LOAD);
                        state_d   = S_IDLE;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            if (k_q == 3'(i + 1)) buf_d[8*i +: 8] = mem_din;
                        end
                        k_d = k_q + 3'd1;
                    end
                end
            end
            S_STORE: begin
                if (k_q < n) begin
                    mem_a    = beat_addr;
                    mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
                    throttle = (beat_addr[17:16] == IO_HI) && io_buffer_full;
                    if (rdy && !throttle) begin
                        mem_wr = 1'b1;
                        k_d    = k_q + 3'd1;
                    end
                end else if (rdy) begin
                    finish_store = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rdy) begin
            if (rollback) begin
                ld_pend_d = '0;
            end else if (load_store_sgn) begin
                ld_pend_d = LD_Q'(1);
                ld_op_d   = load_store_op;
                ld_addr_d = load_store_addr;
            end
            if (st_commit) begin
                st_pend_d = 1'b1;
                st_op_d   = st_op;
                st_addr_d = st_addr;
                st_data_d = st_data;
            end
        end
    end

    assign if_inst   = if_valid  ? asm_val : '0;
    assign mem_res   = mem_valid ? asm_val : '0;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            st_pend_q <= 1'b0;
            st_op_q   <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            ld_pend_q <= '0;
            ld_op_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            buf_q     <= buf_d;
            st_pend_q <= st_pend_d;
            st_op_q   <= st_op_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            ld_pend_q <= ld_pend_d;
            ld_op_q   <= ld_op_d;
            ld_addr_q <= ld_addr_d;
        end
    end

endmodule
